muldiv_unit: RTL and testbench

//   Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core.

---
 rtl/muldiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are fixed up when the result commits.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int FAST_MUL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   operand;
  logic               neg_q;
  logic               neg_r;
  logic               is_div;

  logic               accept;
  logic               is_mul_op;
  logic               is_div_op;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] fast_prod;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;

  // Operand decode, magnitudes and single-iteration datapath steps
  always_comb begin
    accept    = (state == IDLE) && start && !flush;
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    sign_a    = ((op == OP_MULT) || (op == OP_DIV)) && src_a[WIDTH-1];
    sign_b    = ((op == OP_MULT) || (op == OP_DIV)) && src_b[WIDTH-1];
    mag_a     = sign_a ? -src_a : src_a;
    mag_b     = sign_b ? -src_b : src_b;
    fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    if (sign_a ^ sign_b) begin
      fast_prod = -fast_prod;
    end else begin
      fast_prod = fast_prod;
    end
    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} +
                (work[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, work[WIDTH-1:1]};
    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
    end
    last_iter = (count == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && is_mul_op && (FAST_MUL == 0)) begin
          next_state = MUL;
        end else if (accept && is_div_op) begin
          next_state = DIV;
        end else begin
          next_state = IDLE;
        end
      end
      MUL, DIV: begin
        if (flush) begin
          next_state = IDLE;
        end else if (last_iter) begin
          next_state = FIN;
        end else begin
          next_state = state;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Working registers, iteration counter and HI/LO result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
      count   <= {CW{1'b0}};
      work    <= {(2*WIDTH){1'b0}};
      operand <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_div  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                if (FAST_MUL != 0) begin
                  {hi, lo} <= fast_prod;
                  done     <= 1'b1;
                end else begin
                  work    <= {{WIDTH{1'b0}}, mag_b};
                  operand <= mag_a;
                  neg_q   <= sign_a ^ sign_b;
                  neg_r   <= 1'b0;
                  is_div  <= 1'b0;
                  count   <= {CW{1'b0}};
                  busy    <= 1'b1;
                end
              end
              OP_DIV, OP_DIVU: begin
                // A zero divisor leaves an all-ones quotient; skipping its sign fix keeps lo all ones
                work    <= {{WIDTH{1'b0}}, mag_a};
                operand <= mag_b;
                neg_q   <= (sign_a ^ sign_b) && (src_b != {WIDTH{1'b0}});
                neg_r   <= sign_a;
                is_div  <= 1'b1;
                count   <= {CW{1'b0}};
                busy    <= 1'b1;
              end
              OP_MTHI: begin
                hi   <= src_a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= src_a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flush) begin
            busy <= 1'b0;
          end else begin
            work  <= mul_next;
            count <= count + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DIV: begin
          if (flush) begin
            busy <= 1'b0;
          end else begin
            work  <= div_next;
            count <= count + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (is_div) begin
            lo <= neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
            hi <= neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= neg_q ? -work : work;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an iterative instance plus a FAST_MUL instance on shared inputs.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic        f_busy, f_done;
  logic [31:0] f_hi, f_lo;

  int checks = 0;
  int errors = 0;
  int n;
  int d;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .FAST_MUL(0)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(32), .FAST_MUL(1)) dut_fast (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(f_busy), .done(f_done), .hi(f_hi), .lo(f_lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start request at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Wait out a long operation (bounded) and check latency, done pulse and results
  task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el);
    n = 0;
    d = 0;
    while (busy && n < 100) begin
      n++;
      if (done) d++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    chk({tag, " done_while_busy"}, 64'(d), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    chk({tag, " done_pulse_end"}, 64'(done), 64'd0);
  endtask

  // Count done pulses over a window; used after flush and reset
  task automatic count_done(input string tag, input int cycles);
    d = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) d++;
      @(negedge clk);
    end
    chk({tag, " no_done"}, 64'(d), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Signed multiply with a negative operand
    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult busy_at_e0", 64'(busy), 64'd1);
    finish_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // Unsigned max*max on both instances
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("fast busy", 64'(f_busy), 64'd0);
    chk("fast done", 64'(f_done), 64'd1);
    chk("fast hi", 64'(f_hi), 64'h0000_0000_FFFF_FFFE);
    chk("fast lo", 64'(f_lo), 64'h0000_0000_0000_0001);
    finish_op("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    finish_op("div neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'd3, 32'h0000_0007, 32'hFFFF_FFFE);
    finish_op("div negb", 32'h0000_0001, 32'hFFFF_FFFD);
    issue(3'd4, 32'h0000_0007, 32'h0000_0000);
    finish_op("divu zero", 32'h0000_0007, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0000);
    finish_op("div zero", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div ovf", 32'h0000_0000, 32'h8000_0000);
    issue(3'd4, 32'd100, 32'd7);
    finish_op("divu 100/7", 32'd2, 32'd14);

    // NONE and reserved opcodes leave everything alone
    issue(3'd0, 32'h1111_1111, 32'h2222_2222);
    chk("none busy", 64'(busy), 64'd0);
    chk("none done", 64'(done), 64'd0);
    issue(3'd7, 32'h1111_1111, 32'h2222_2222);
    chk("rsvd busy", 64'(busy), 64'd0);
    chk("rsvd done", 64'(done), 64'd0);
    chk("rsvd hi", 64'(hi), 64'd2);
    chk("rsvd lo", 64'(lo), 64'd14);

    issue(3'd5, 32'h0000_1234, 32'h0);
    chk("mthi done", 64'(done), 64'd1);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo", 64'(lo), 64'd14);

    // Divide flushed on its 10th busy cycle, with an ignored start on the 4th
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 3'd6;
    src_a = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    repeat (5) @(negedge clk);
    chk("flush busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush done", 64'(done), 64'd0);
    chk("flush hi", 64'(hi), 64'h1234);
    chk("flush lo", 64'(lo), 64'd14);
    count_done("flush", 40);
    chk("flush lo_after", 64'(lo), 64'd14);

    // flush wins over start in IDLE
    flush = 1'b1;
    issue(3'd6, 32'h0000_9999, 32'h0);
    flush = 1'b0;
    chk("idle_flush done", 64'(done), 64'd0);
    chk("idle_flush lo", 64'(lo), 64'd14);

    // flush in the FIN cycle is too late
    issue(3'd4, 32'd50, 32'd7);
    repeat (32) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fin_flush done", 64'(done), 64'd1);
    chk("fin_flush hi", 64'(hi), 64'd1);
    chk("fin_flush lo", 64'(lo), 64'd7);

    // Reset on the 5th busy cycle of a multiply
    issue(3'd6, 32'h0000_ABCD, 32'h0);
    chk("mtlo lo", 64'(lo), 64'hABCD);
    chk("mtlo hi", 64'(hi), 64'd1);
    issue(3'd1, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    reset = 1'b0;
    count_done("midrst", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
